// File: rtl/aes_key_expand.sv
// AES-128 key expansion: emits round keys 0..10 over a valid/ready stream, one key per accepted transfer.
// Optional feature macro AES_KEYEXP_REPLAY_EN adds a replay input that re-emits the schedule from the retained cipher key.
module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
`ifdef AES_KEYEXP_REPLAY_EN
    input  logic         replay,
`endif
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] round_key,
    output logic         busy,
    output logic         done
);

    // Handshake: a round key transfers on any rising edge where rk_valid and rk_ready are both high;
    // while rk_ready is low the presented key, its index and rcon stay frozen.

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    state_t         state, state_next;
    logic [127:0]   key_reg;
    logic [7:0]     rcon;
    logic           xfer, last, replay_go;
    logic [31:0]    w0, w1, w2, w3, t, nw0, nw1, nw2, nw3;
    logic [127:0]   next_key;

`ifdef AES_KEYEXP_REPLAY_EN
    logic [127:0]   cipher_key;
    assign replay_go = replay;
`else
    assign replay_go = 1'b0;
`endif

    // Words hold bytes in internal order: byte 4j+b of the key sits at bits [8b+7:8b] of word j.
    assign w0 = key_reg[31:0];
    assign w1 = key_reg[63:32];
    assign w2 = key_reg[95:64];
    assign w3 = key_reg[127:96];

    // RotWord then SubWord, rcon folded into the first byte of the rotated word.
    assign t   = {sbox(w3[7:0]), sbox(w3[31:24]), sbox(w3[23:16]), sbox(w3[15:8]) ^ rcon};
    assign nw0 = w0 ^ t;
    assign nw1 = w1 ^ nw0;
    assign nw2 = w2 ^ nw1;
    assign nw3 = w3 ^ nw2;
    assign next_key = {nw3, nw2, nw1, nw0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start || replay_go) state_next = EMIT;
            EMIT: if (last)               state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_comb begin
        rk_valid  = (state == EMIT);
        busy      = (state == EMIT);
        xfer      = (state == EMIT) && rk_ready;
        last      = xfer && (rk_round == 4'd10);
        round_key = key_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg  <= '0;
            rcon     <= 8'h01;
            rk_round <= 4'd0;
            done     <= 1'b0;
`ifdef AES_KEYEXP_REPLAY_EN
            cipher_key <= '0;
`endif
        end else begin
            done <= last;
            if (state == IDLE && start) begin
                key_reg  <= key_in;
                rcon     <= 8'h01;
                rk_round <= 4'd0;
`ifdef AES_KEYEXP_REPLAY_EN
                cipher_key <= key_in;
`endif
            end else if (state == IDLE && replay_go) begin
`ifdef AES_KEYEXP_REPLAY_EN
                key_reg  <= cipher_key;
`endif
                rcon     <= 8'h01;
                rk_round <= 4'd0;
            end else if (xfer && !last) begin
                key_reg  <= next_key;
                rcon     <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                rk_round <= rk_round + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 schedule vectors, stalls, ignored starts, mid-run reset
// and (with AES_KEYEXP_REPLAY_EN) replay of the retained key.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [3:0]   rk_round;
    logic [127:0] round_key;
    logic         busy;
    logic         done;
`ifdef AES_KEYEXP_REPLAY_EN
    logic         replay;
`endif

    int errors = 0;
    int checks = 0;

    logic [127:0] got_keys [0:10];
    logic [127:0] ref_keys [0:10];

    typedef struct {
        logic [127:0] key;    // FIPS byte order
        int           round;
        logic [127:0] exp;    // FIPS byte order
        int           stall;  // percent of cycles with rk_ready low
    } vec_t;

    vec_t vecs [13];

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K0 = 128'h0;

    aes_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
`ifdef AES_KEYEXP_REPLAY_EN
        .replay    (replay),
`endif
        .rk_ready  (rk_ready),
        .rk_valid  (rk_valid),
        .rk_round  (rk_round),
        .round_key (round_key),
        .busy      (busy),
        .done      (done)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] bswap(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = x[127-8*i -: 8];
        return y;
    endfunction

    // Scoreboard
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Drivers (inputs change on the falling edge, outputs sampled there too)
    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        rk_ready = 1'b0;
        key_in = '0;
`ifdef AES_KEYEXP_REPLAY_EN
        replay = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Launch a run (mode 0 = start, 1 = replay) and collect all 11 keys into got_keys.
    task automatic expand(input logic [127:0] key_int, input int mode, input int stall);
        int n = 0;
        bit stalled = 1'b0;
        bit aborted = 1'b0;
        logic [127:0] held;
        for (int i = 0; i < 11; i++) got_keys[i] = 'x;
        key_in = key_int;
        rk_ready = 1'b0;
        if (mode == 0) start = 1'b1;
`ifdef AES_KEYEXP_REPLAY_EN
        if (mode == 1) replay = 1'b1;
`endif
        @(negedge clk);
        start = 1'b0;
`ifdef AES_KEYEXP_REPLAY_EN
        replay = 1'b0;
`endif
        check("latency_valid", rk_valid, 1'b1);
        check("busy_in_emit", busy, 1'b1);
        for (int cyc = 0; cyc < 400 && n < 11 && !aborted; cyc++) begin
            if (!rk_valid) begin
                aborted = 1'b1;
                rk_ready = 1'b0;
            end else begin
                if (stalled) check("hold_key", round_key, held);
                check("rk_round_seq", rk_round, n);
                rk_ready = ($urandom_range(0, 99) >= stall);
                if (rk_ready) begin
                    got_keys[n] = round_key;
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = round_key;
                end
                @(negedge clk);
            end
        end
        rk_ready = 1'b0;
        check("xfer_count", n, 11);
        check("done_pulse", done, 1'b1);
        check("valid_drop", rk_valid, 1'b0);
        check("busy_drop", busy, 1'b0);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
    endtask

    // Accept keys until the given round is presented, leaving rk_ready low.
    task automatic wait_round(input logic [3:0] r);
        bit hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (rk_valid && rk_round == r) begin
                hit = 1'b1;
                rk_ready = 1'b0;
            end else begin
                rk_ready = 1'b1;
                @(negedge clk);
            end
        end
        check("wait_round", hit, 1'b1);
    endtask

    initial begin
        logic [127:0] last_key;
        int highs;

        vecs[0]  = '{K1, 0,  K1, 0};
        vecs[1]  = '{K1, 1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 0};
        vecs[2]  = '{K1, 2,  128'hb692cf0b643dbdf1be9bc5006830b3fe, 0};
        vecs[3]  = '{K1, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 0};
        vecs[4]  = '{K2, 0,  K2, 50};
        vecs[5]  = '{K2, 1,  128'ha0fafe1788542cb123a339392a6c7605, 50};
        vecs[6]  = '{K2, 2,  128'hf2c295f27a96b9435935807a7359f67f, 50};
        vecs[7]  = '{K2, 3,  128'h3d80477d4716fe3e1e237e446d7a883b, 50};
        vecs[8]  = '{K2, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 50};
        vecs[9]  = '{K0, 0,  K0, 30};
        vecs[10] = '{K0, 1,  128'h62636363626363636263636362636363, 30};
        vecs[11] = '{K0, 2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 30};
        vecs[12] = '{K0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 30};

        do_reset();
        @(negedge clk);
        check("rst_valid", rk_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_round", rk_round, 4'd0);
        check("rst_key", round_key, 128'h0);

`ifdef AES_KEYEXP_REPLAY_EN
        // Replay before any start emits the schedule of the all-zero key
        expand('0, 1, 0);
        check("replay_zero_r0", got_keys[0], 128'h0);
        check("replay_zero_r1", got_keys[1], bswap(128'h62636363626363636263636362636363));
`endif

        // Table-driven schedule vectors
        last_key = 'x;
        for (int i = 0; i < 13; i++) begin
            if (i == 0 || vecs[i].key !== last_key) begin
                expand(bswap(vecs[i].key), 0, vecs[i].stall);
                last_key = vecs[i].key;
            end
            check($sformatf("vec%0d_round%0d", i, vecs[i].round),
                  got_keys[vecs[i].round], bswap(vecs[i].exp));
        end

        // Idle holds the round 10 key and index
        repeat (3) @(negedge clk);
        check("idle_hold_key", round_key, bswap(128'hb4ef5bcb3e92e21123e951cf6f8f188e));
        check("idle_hold_round", rk_round, 4'd10);
        check("idle_valid", rk_valid, 1'b0);

        // Start during EMIT is ignored; start coinciding with the final transfer is ignored too
        key_in = bswap(K2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_round(4'd4);
        start = 1'b1;
        key_in = bswap(K1);
        rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ignore_start_round", rk_round, 4'd5);
        wait_round(4'd10);
        check("ignore_start_key", round_key, bswap(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        rk_ready = 1'b1;
        start = 1'b1;
        key_in = bswap(K1);
        @(negedge clk);
        start = 1'b0;
        rk_ready = 1'b0;
        check("last_start_done", done, 1'b1);
        check("last_start_valid", rk_valid, 1'b0);
        @(negedge clk);
        check("last_start_stay_idle", rk_valid, 1'b0);
        check("last_start_key", round_key, bswap(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

`ifdef AES_KEYEXP_REPLAY_EN
        // Replay re-emits the retained key's schedule (K2, the ignored start left it alone)
        expand(bswap(K2), 0, 0);
        for (int i = 0; i < 11; i++) ref_keys[i] = got_keys[i];
        expand(bswap(K1), 1, 40);
        for (int i = 0; i < 11; i++) check($sformatf("replay_r%0d", i), got_keys[i], ref_keys[i]);
        check("replay_r10_abs", got_keys[10], bswap(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
`endif

        // Reset at round 6 aborts with no done pulse; rst beats start and rk_ready
        key_in = bswap(K1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_round(4'd6);
        rst = 1'b1;
        start = 1'b1;
        rk_ready = 1'b1;
        @(negedge clk);
        check("midrst_valid", rk_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_round", rk_round, 4'd0);
        check("midrst_key", round_key, 128'h0);
        rst = 1'b0;
        start = 1'b0;
        highs = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || rk_valid) highs++;
        end
        rk_ready = 1'b0;
        check("midrst_no_restart", highs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 Parameter: none; AES-128 only (128-bit key, 11 round keys, rounds 0..10).
REQ-002 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request expansion of key_in; sampled only in IDLE.
REQ-005 key_in  in  128  cipher key, internal byte order: byte i at bits [8i+7:8i], byte 0 = first FIPS-197 byte.
REQ-006 rk_ready  in  1  consumer accepts current round key.
REQ-007 rk_valid  out  1  round_key/rk_round valid.
REQ-008 rk_round  out  4  index 0..10 of the presented key.
REQ-009 round_key  out  128  round key, same internal byte order as key_in; drives the round stage's round_key directly.
REQ-010 busy  out  1  high in EMIT state.
REQ-011 done  out  1  one-cycle pulse after round 10 key accepted.

Function
REQ-012 FSM states SHALL be IDLE and EMIT only.
REQ-013 IDLE with start=1: SHALL capture key_in into key register, load rcon=0x01, rk_round=0, and enter EMIT next cycle.
REQ-014 In EMIT, rk_valid SHALL be 1; round_key SHALL equal the registered key for rk_round.
REQ-015 Latency: round 0 key (= key_in) SHALL be presented the cycle after start is sampled.
REQ-016 Transfer occurs on a cycle with rk_valid=1 and rk_ready=1; next key SHALL appear the following cycle (one key per cycle at full throughput).
REQ-017 rk_ready=0 SHALL hold round_key, rk_round, rcon unchanged for any number of cycles.
REQ-018 Next key: t = SubWord(RotWord(w3)) XOR {rcon,00,00,00}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2' (FIPS-197 words, w0 = bytes 0..3).
REQ-019 SubWord SHALL use four forward AES S-box lookups (FIPS-197 S-box table); combinational, single cycle.
REQ-020 rcon SHALL step by xtime per transfer: 01,02,04,08,10,20,40,80,1b,36; 8-bit, reduction by 0x1b on overflow.
REQ-021 Transfer with rk_round=10: SHALL return to IDLE, drop rk_valid and busy next cycle, pulse done for exactly that cycle.
REQ-022 start while in EMIT SHALL be ignored; key register unaffected.
REQ-023 start and final transfer in same cycle: start ignored (state is EMIT when sampled).
REQ-024 In IDLE, round_key SHALL hold the last key presented (round 10 after completion); rk_round holds 10.
REQ-025 rk_round SHALL never exceed 10; no wrap to 0 except via new start.

Reset
REQ-026 rst=1 SHALL force IDLE, rk_valid=0, busy=0, done=0, rk_round=0, rcon=0x01, round_key=0, key register=0, regardless of state.
REQ-027 Reset mid-EMIT SHALL abort the sequence; no done pulse; start required again.
REQ-028 rst has priority over start and rk_ready in the same cycle.

Configuration
REQ-029 Macro AES_KEYEXP_REPLAY_EN: when defined, SHALL add input port replay (1 bit) and a 128-bit cipher-key register retained after completion.
REQ-030 With AES_KEYEXP_REPLAY_EN: replay=1 in IDLE (start=0) SHALL re-emit rounds 0..10 from the retained key, identical to REQ-013..021; start has priority over replay; replay before any start after reset emits from key 0.
REQ-031 Without AES_KEYEXP_REPLAY_EN: port replay and retained-key register SHALL not exist; behaviour otherwise identical.

Verification
REQ-032 key_in=bswap(000102030405060708090a0b0c0d0e0f), start pulse, rk_ready=1 -> cycle+1 round 0 = key; cycle+2 rk_round=1, bswap(round_key)=d6aa74fdd2af72fadaa678f1d6ab76fe; rk_round=10 key=13111d7fe3944a17f307a78b4d2b30c5; done one cycle later; 11 transfers total.
REQ-033 key 2b7e151628aed2a6abf7158809cf4f3c -> round 1 a0fafe1788542cb123a339392a6c7605, round 10 d014f9a8c9ee2589e13f0cc8b6630ca6 (external byte order).
REQ-034 rk_ready toggled randomly -> same 11 keys in order, each held stable while rk_ready=0; no skipped or duplicated rounds.
REQ-035 start with new key during EMIT at round 4 -> ignored, sequence completes with original key; rst at round 6 -> all outputs zero next cycle, no done.
REQ-036 AES_KEYEXP_REPLAY_EN defined: complete run, then replay pulse -> identical 11-key sequence; macro undefined: build without replay port passes REQ-032.
